fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 11 +
 rtl/fetch_queue.sv | 75 +++++++
 tb/tb_fetch_queue.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared widths, default geometry and entry layout for the fetch queue
package fetch_queue_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int FQ_DEPTH    = 8;
  localparam int FQ_POP_W    = 2;
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular fetch buffer between icache and decode, one push and up to POP_W in-order pops per cycle
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int POP_W = FQ_POP_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         stall,
  input  logic                         in_valid,
  input  logic [INST_ADDR_W-1:0]       in_pc,
  input  logic [INST_W-1:0]            in_inst,
  output logic                         in_ready,
  output logic [POP_W-1:0]             out_valid,
  input  logic [POP_W-1:0]             out_ready,
  output logic [INST_ADDR_W*POP_W-1:0] out_pc,
  output logic [INST_W*POP_W-1:0]      out_inst,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fq_entry_t      mem_q [DEPTH];
  logic [AW:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d, n_pop;
  logic [AW-1:0]  lane_idx;
  logic [POP_W-1:0] pop;
  logic           push, chain;
  // space is judged on registered occupancy only, so a pop never frees room for a same-cycle push
  assign in_ready = rst && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign count    = count_q;
  // lane presentation and in-order pop chain: a lane pops only if every lower lane pops
  always_comb begin
    out_valid = '0;
    out_pc    = '0;
    out_inst  = '0;
    pop       = '0;
    n_pop     = '0;
    chain     = 1'b1;
    lane_idx  = '0;
    for (int i = 0; i < POP_W; i++) begin
      lane_idx     = rd_ptr_q[AW-1:0] + AW'(i);
      out_valid[i] = !stall && (count_q > CW'(i));
      out_pc[INST_ADDR_W*i +: INST_ADDR_W] = out_valid[i] ? mem_q[lane_idx].pc : '0;
      out_inst[INST_W*i +: INST_W]         = out_valid[i] ? mem_q[lane_idx].inst : '0;
      pop[i]       = chain && out_valid[i] && out_ready[i];
      chain        = pop[i];
      n_pop        = n_pop + CW'(pop[i]);
    end
  end
  // next pointers and occupancy; flush wins over any push or pop
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + n_pop;
    count_d  = flush ? '0 : count_q + CW'(push) - n_pop;
  end
  // pointer and occupancy registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  // entry storage is never cleared; stale contents are hidden behind out_valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{pc: in_pc, inst: in_inst};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed table, hand sequences and random traffic checked against a queue model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int POP_W = 2;
  logic        clk = 0, rst = 0, flush = 0, stall = 0, in_valid = 0;
  logic [31:0] in_pc = 0, in_inst = 0;
  logic        in_ready;
  logic [1:0]  out_valid, out_ready = 0;
  logic [63:0] out_pc, out_inst;
  logic [2:0]  count;
  int          n_chk = 0, n_fail = 0;
  logic [63:0] q[$];
  typedef struct {
    bit fl, st, iv;
    bit [1:0] rdy;
    bit [31:0] pc;
    int e_cnt;
    bit e_ir;
    bit [1:0] e_ov;
    bit [31:0] e_pc0;
  } vec_t;
  vec_t vt[17];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .POP_W(POP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .count(count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit f, input bit s, input bit v, input bit [1:0] r, input bit [31:0] pc);
    flush = f; stall = s; in_valid = v; out_ready = r; in_pc = pc; in_inst = pc ^ 32'h1357_9BDF;
  endtask

  // expected outputs come straight from the model queue contents
  task automatic check_model(input string tag);
    logic [1:0]  ev;
    logic [63:0] epc, einst;
    ev = '0; epc = '0; einst = '0;
    for (int i = 0; i < POP_W; i++)
      if (!stall && q.size() > i) begin
        ev[i] = 1'b1;
        epc[32*i +: 32]   = q[i][63:32];
        einst[32*i +: 32] = q[i][31:0];
      end
    chk({tag, " count"}, 64'(count), 64'(q.size()));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(rst && q.size() < DEPTH));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, " out_pc"}, out_pc, epc);
    chk({tag, " out_inst"}, out_inst, einst);
  endtask

  task automatic cycle(input string tag);
    int n;
    bit push;
    #1;
    check_model(tag);
    n = 0;
    if (!stall && q.size() > 0 && out_ready[0]) begin
      n = 1;
      if (q.size() > 1 && out_ready[1]) n = 2;
    end
    push = in_valid && rst && q.size() < DEPTH && !flush;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      repeat (n) void'(q.pop_front());
      if (push) q.push_back({in_pc, in_pc ^ 32'h1357_9BDF});
    end
    #1;
  endtask

  initial begin
    //       fl st iv rdy    pc              cnt ir ov     pc0
    vt[0]  = '{0, 0, 1, 2'b00, 32'hBFC00000, 0, 1, 2'b00, 32'h0};
    vt[1]  = '{0, 0, 1, 2'b00, 32'hBFC00004, 1, 1, 2'b01, 32'hBFC00000};
    vt[2]  = '{0, 0, 1, 2'b00, 32'hBFC00008, 2, 1, 2'b11, 32'hBFC00000};
    vt[3]  = '{0, 0, 1, 2'b00, 32'hBFC0000C, 3, 1, 2'b11, 32'hBFC00000};
    vt[4]  = '{0, 0, 1, 2'b00, 32'hBFC00010, 4, 0, 2'b11, 32'hBFC00000};
    vt[5]  = '{0, 0, 1, 2'b11, 32'hBFC00010, 4, 0, 2'b11, 32'hBFC00000};
    vt[6]  = '{0, 0, 1, 2'b00, 32'hBFC00010, 2, 1, 2'b11, 32'hBFC00008};
    vt[7]  = '{0, 0, 0, 2'b10, 32'h0,        3, 1, 2'b11, 32'hBFC00008};
    vt[8]  = '{0, 0, 0, 2'b01, 32'h0,        3, 1, 2'b11, 32'hBFC00008};
    vt[9]  = '{0, 0, 0, 2'b00, 32'h0,        2, 1, 2'b11, 32'hBFC0000C};
    vt[10] = '{0, 0, 1, 2'b00, 32'hBFC00014, 2, 1, 2'b11, 32'hBFC0000C};
    vt[11] = '{1, 0, 1, 2'b11, 32'hBFC00018, 3, 1, 2'b11, 32'hBFC0000C};
    vt[12] = '{0, 0, 0, 2'b00, 32'h0,        0, 1, 2'b00, 32'h0};
    vt[13] = '{0, 0, 1, 2'b00, 32'hBFC00020, 0, 1, 2'b00, 32'h0};
    vt[14] = '{0, 0, 1, 2'b00, 32'hBFC00024, 1, 1, 2'b01, 32'hBFC00020};
    vt[15] = '{0, 1, 0, 2'b11, 32'h0,        2, 1, 2'b00, 32'h0};
    vt[16] = '{0, 0, 0, 2'b00, 32'h0,        2, 1, 2'b11, 32'hBFC00020};

    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    #3 rst = 1;
    for (int k = 0; k < 17; k++) begin
      drive(vt[k].fl, vt[k].st, vt[k].iv, vt[k].rdy, vt[k].pc);
      #1;
      chk($sformatf("vec%0d count", k), 64'(count), 64'(vt[k].e_cnt));
      chk($sformatf("vec%0d in_ready", k), 64'(in_ready), 64'(vt[k].e_ir));
      chk($sformatf("vec%0d out_valid", k), 64'(out_valid), 64'(vt[k].e_ov));
      chk($sformatf("vec%0d lane0_pc", k), 64'(out_pc[31:0]), 64'(vt[k].e_pc0));
      cycle($sformatf("vec%0d", k));
    end

    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 1, (k % 2) ? 2'b11 : 2'b01, 32'hC000_0000 + 32'(k) * 4);
      cycle($sformatf("wrap%0d", k));
    end
    drive(0, 0, 0, 2'b00, 32'h0);
    #2 rst = 0;
    q.delete();
    #1;
    check_model("async_rst");
    chk("async_rst count_zero", 64'(count), 64'(0));
    chk("async_rst in_ready_zero", 64'(in_ready), 64'(0));
    drive(0, 0, 1, 2'b00, 32'hDEAD_0000);
    cycle("rst_held");
    #2 rst = 1;
    drive(0, 0, 1, 2'b00, 32'hBFC00100);
    cycle("post_rst_push");
    drive(0, 0, 0, 2'b00, 32'h0);
    cycle("post_rst_seen");

    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            2'($urandom), 32'h8000_0000 + 32'(k) * 4);
      cycle($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
